// File: rtl/beam_sum_accumulator.sv
// Delay-and-sum frame accumulator: adds NUM_CH signed samples in a guard-bit
// accumulator and hands out one saturated WIDTH-bit sum per frame.
module beam_sum_accumulator #(
  parameter int WIDTH  = 23,
  parameter int NUM_CH = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic                      out_sat,
  output logic [$clog2(NUM_CH)-1:0] ch_idx
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid never depends combinationally on ready.

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int GUARD = CH_W;
  localparam int ACC_W = WIDTH + GUARD;

  localparam logic signed [ACC_W-1:0] MAX_V = {{(GUARD+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MIN_V = {{(GUARD+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0]        POS_CLIP = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0]        NEG_CLIP = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] in_ext;
  logic signed [ACC_W-1:0] sum;
  logic                    accept;
  logic                    last;
  logic                    out_fire;
  logic [WIDTH-1:0]        sat_data;
  logic                    sat_flag;

  assign in_ext   = {{GUARD{in_data[WIDTH-1]}}, in_data};
  assign sum      = acc_q + in_ext;
  assign accept   = in_valid && in_ready && !clr;
  assign last     = (ch_idx == CH_W'(NUM_CH - 1));
  assign out_fire = out_valid && out_ready && !clr;

  // Clip the wide sum into the WIDTH-bit two's complement range.
  always_comb begin
    sat_data = sum[WIDTH-1:0];
    sat_flag = 1'b0;
    if (sum > MAX_V) begin
      sat_data = POS_CLIP;
      sat_flag = 1'b1;
    end else if (sum < MIN_V) begin
      sat_data = NEG_CLIP;
      sat_flag = 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clr overrides any same-cycle transfer.
  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = ACCUM;
    end else begin
      case (state_q)
        ACCUM:   if (accept && last) state_d = HOLD;
        HOLD:    if (out_fire)       state_d = ACCUM;
        default: state_d = ACCUM;
      endcase
    end
  end

  // Output logic
  always_comb begin
    in_ready = 1'b0;
    case (state_q)
      ACCUM:   in_ready = 1'b1;
      HOLD:    in_ready = 1'b0;
      default: in_ready = 1'b0;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      ch_idx    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      acc_q     <= '0;
      ch_idx    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        if (last) begin
          acc_q     <= '0;
          ch_idx    <= '0;
          out_valid <= 1'b1;
          out_data  <= sat_data;
          out_sat   <= sat_flag;
        end else begin
          acc_q  <= sum;
          ch_idx <= ch_idx + CH_W'(1);
        end
      end
      if (out_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  a_hold_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready && !clr) |=> (out_valid && $stable(out_data) && $stable(out_sat)));
  a_no_input_in_hold: assert property (@(posedge clk) disable iff (!rst_n)
    out_valid |-> !in_ready);
  a_ch_idx_range: assert property (@(posedge clk) disable iff (!rst_n)
    ch_idx <= CH_W'(NUM_CH - 1));
`endif

endmodule

// File: tb/tb_beam_sum_accumulator.sv
// Directed bench for beam_sum_accumulator: a NUM_CH=4 instance for most
// scenarios and a NUM_CH=8 instance for the wide-frame saturation case.
module tb_beam_sum_accumulator;

  localparam int W = 23;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;

  logic         clr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_data;
  logic         out_sat;
  logic [1:0]   ch_idx;

  logic         clr8 = 1'b0;
  logic         in_valid8 = 1'b0;
  logic         in_ready8;
  logic [W-1:0] in_data8 = '0;
  logic         out_valid8;
  logic         out_ready8 = 1'b1;
  logic [W-1:0] out_data8;
  logic         out_sat8;
  logic [2:0]   ch_idx8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  beam_sum_accumulator #(.WIDTH(W), .NUM_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_sat(out_sat), .ch_idx(ch_idx)
  );

  beam_sum_accumulator #(.WIDTH(W), .NUM_CH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .clr(clr8),
    .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .out_data(out_data8), .out_sat(out_sat8), .ch_idx(ch_idx8)
  );

  // Hold a sample on the input until an edge with in_ready high takes it.
  // Leaves in_valid high; returns 1 ns after the accepting edge.
  task automatic push(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      $display("FAIL push_timeout got in_ready=0 for 20 cycles, need 1");
    end
  endtask

  task automatic push8(input logic [W-1:0] d);
    bit done;
    done = 1'b0;
    in_valid8 = 1'b1;
    in_data8  = d;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready8;
      @(posedge clk); #1;
    end
    if (!done) begin
      total++;
      $display("FAIL push8_timeout got in_ready=0 for 20 cycles, need 1");
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else passed++;
    total++; if (out_data !== 23'h0) $display("FAIL rst_out_data got %h exp 0", out_data); else passed++;
    total++; if (out_sat !== 1'b0) $display("FAIL rst_out_sat got %b exp 0", out_sat); else passed++;
    total++; if (ch_idx !== 2'd0) $display("FAIL rst_ch_idx got %0d exp 0", ch_idx); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_basic_sum();
    out_ready = 1'b1;
    push(23'd1); push(23'd1); push(23'd1); push(23'd1);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL t1_latency got out_valid=%b exp 1", out_valid); else passed++;
    total++; if (out_data !== 23'd4) $display("FAIL t1_data got %h exp %h", out_data, 23'd4); else passed++;
    total++; if (out_sat !== 1'b0) $display("FAIL t1_sat got %b exp 0", out_sat); else passed++;
    @(posedge clk); #1;
    total++; if (out_valid !== 1'b0) $display("FAIL t1_one_cycle got out_valid=%b exp 0", out_valid); else passed++;
    total++; if (out_data !== 23'd4) $display("FAIL t1_retain got %h exp %h", out_data, 23'd4); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL t1_ready_back got %b exp 1", in_ready); else passed++;
  endtask

  task automatic test_signed_gaps();
    push(23'h7FFFFE);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (ch_idx !== 2'd1) $display("FAIL t2_gap_hold got ch_idx=%0d exp 1", ch_idx); else passed++;
    push(23'd1); push(23'h7FFFF0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    push(23'd8);
    in_valid = 1'b0;
    total++; if (out_valid !== 1'b1) $display("FAIL t2_valid got %b exp 1", out_valid); else passed++;
    total++; if (out_data !== 23'h7FFFF7) $display("FAIL t2_data got %h exp %h", out_data, 23'h7FFFF7); else passed++;
    total++; if (out_sat !== 1'b0) $display("FAIL t2_sat got %b exp 0", out_sat); else passed++;
  endtask

  task automatic test_saturation();
    repeat (4) push(23'h3FFFFF);
    in_valid = 1'b0;
    total++; if (out_data !== 23'h3FFFFF) $display("FAIL t3_pos_data got %h exp %h", out_data, 23'h3FFFFF); else passed++;
    total++; if (out_sat !== 1'b1) $display("FAIL t3_pos_sat got %b exp 1", out_sat); else passed++;
    repeat (4) push(23'h400000);
    in_valid = 1'b0;
    total++; if (out_data !== 23'h400000) $display("FAIL t3_neg_data got %h exp %h", out_data, 23'h400000); else passed++;
    total++; if (out_sat !== 1'b1) $display("FAIL t3_neg_sat got %b exp 1", out_sat); else passed++;
    push(23'h3FFFFF); push(23'd1); push(23'h7FFFFF); push(23'd0);
    in_valid = 1'b0;
    total++; if (out_data !== 23'h3FFFFF) $display("FAIL t3_edge_data got %h exp %h", out_data, 23'h3FFFFF); else passed++;
    total++; if (out_sat !== 1'b0) $display("FAIL t3_edge_sat got %b exp 0", out_sat); else passed++;
  endtask

  task automatic test_backpressure();
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) push(23'd3);
    in_data = 23'd7;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) $display("FAIL t4_in_ready c%0d got %b exp 0", i, in_ready); else passed++;
      total++; if (out_valid !== 1'b1) $display("FAIL t4_valid c%0d got %b exp 1", i, out_valid); else passed++;
      total++; if (out_data !== 23'd12) $display("FAIL t4_stable c%0d got %h exp %h", i, out_data, 23'd12); else passed++;
    end
    total++; if (ch_idx !== 2'd0) $display("FAIL t4_ignored got ch_idx=%0d exp 0", ch_idx); else passed++;
    out_ready = 1'b1;
    push(23'd7);
    total++; if (ch_idx !== 2'd1) $display("FAIL t4_first_kept got ch_idx=%0d exp 1", ch_idx); else passed++;
    push(23'd1); push(23'd1); push(23'd1);
    in_valid = 1'b0;
    total++; if (out_data !== 23'd10) $display("FAIL t4_next_frame got %h exp %h", out_data, 23'd10); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    @(posedge clk); #1;
    push(23'd9); push(23'd9);
    in_valid = 1'b0;
    total++; if (ch_idx !== 2'd2) $display("FAIL t5_pre got ch_idx=%0d exp 2", ch_idx); else passed++;
    rst_n = 1'b0;
    #2;
    total++; if (ch_idx !== 2'd0) $display("FAIL t5_async_idx got %0d exp 0", ch_idx); else passed++;
    total++; if (out_data !== 23'd0) $display("FAIL t5_async_data got %h exp 0", out_data); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL t5_async_valid got %b exp 0", out_valid); else passed++;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    repeat (4) push(23'd5);
    in_valid = 1'b0;
    total++; if (out_data !== 23'd20) $display("FAIL t5_fresh got %h exp %h", out_data, 23'd20); else passed++;
  endtask

  task automatic test_clear();
    @(posedge clk); #1;
    push(23'd2); push(23'd2);
    clr = 1'b1; in_valid = 1'b1; in_data = 23'd100;
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    total++; if (ch_idx !== 2'd0) $display("FAIL t6_clr_idx got %0d exp 0", ch_idx); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL t6_clr_valid got %b exp 0", out_valid); else passed++;
    repeat (4) push(23'd2);
    in_valid = 1'b0;
    total++; if (out_data !== 23'd8) $display("FAIL t6_after_clr got %h exp %h", out_data, 23'd8); else passed++;
    @(posedge clk); #1;
    out_ready = 1'b0;
    repeat (4) push(23'd1);
    in_valid = 1'b0;
    clr = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    total++; if (out_valid !== 1'b0) $display("FAIL t6_hold_drop got %b exp 0", out_valid); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL t6_hold_ready got %b exp 1", in_ready); else passed++;
    out_ready = 1'b1;
    repeat (4) push(23'd6);
    in_valid = 1'b0;
    total++; if (out_data !== 23'd24) $display("FAIL t6_resume got %h exp %h", out_data, 23'd24); else passed++;
  endtask

  task automatic test_wide_frame();
    repeat (8) push8(23'h3FFFFF);
    in_valid8 = 1'b0;
    total++; if (out_valid8 !== 1'b1) $display("FAIL t7_valid got %b exp 1", out_valid8); else passed++;
    total++; if (out_data8 !== 23'h3FFFFF) $display("FAIL t7_pos_data got %h exp %h", out_data8, 23'h3FFFFF); else passed++;
    total++; if (out_sat8 !== 1'b1) $display("FAIL t7_pos_sat got %b exp 1", out_sat8); else passed++;
    repeat (8) push8(23'h400000);
    in_valid8 = 1'b0;
    total++; if (out_data8 !== 23'h400000) $display("FAIL t7_neg_data got %h exp %h", out_data8, 23'h400000); else passed++;
    repeat (4) push8(23'd1);
    in_valid8 = 1'b0;
    total++; if (out_valid8 !== 1'b0) $display("FAIL t7_no_early got %b exp 0", out_valid8); else passed++;
    total++; if (ch_idx8 !== 3'd4) $display("FAIL t7_idx got %0d exp 4", ch_idx8); else passed++;
    repeat (4) push8(23'd1);
    in_valid8 = 1'b0;
    total++; if (out_data8 !== 23'd8) $display("FAIL t7_sum8 got %h exp %h", out_data8, 23'd8); else passed++;
    total++; if (out_sat8 !== 1'b0) $display("FAIL t7_sat8 got %b exp 0", out_sat8); else passed++;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_sum();
    test_signed_gaps();
    test_saturation();
    test_backpressure();
    test_reset_mid_frame();
    test_clear();
    test_wide_frame();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
